// File: rtl/rsa_pkg.sv
// Shared defaults and sequencer state type for the RSA decrypt path.
package rsa_pkg;

   localparam int RSA_ARQ     = 16;
   localparam int RSA_ADDR    = 18;
   localparam int RSA_KEY_N   = 1927;
   localparam int RSA_KEY_D   = 1349;
   localparam int RSA_TIMEOUT = 65535;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LAUNCH,
      S_WAIT,
      S_EMIT,
      S_FINISH
   } rsa_seq_state_t;

endpackage

// File: rtl/rsa_addr_counter.sv
// Word address / remaining-count tracker: load on start, step per accepted word.
// Latency: registered, updates on the edge after load/step; no backpressure of its own.
module rsa_addr_counter
   import rsa_pkg::*;
#(
   parameter int ADDR = RSA_ADDR
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_load,
   input  logic [ADDR-1:0] i_base,
   input  logic [ADDR-1:0] i_count,
   input  logic            i_step,
   output logic [ADDR-1:0] o_addr,
   output logic            o_last
);

   logic [ADDR-1:0] r_addr;
   logic [ADDR-1:0] r_remain;

   // Address wraps naturally at 2^ADDR.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr   <= '0;
         r_remain <= '0;
      end else if (i_load) begin
         r_addr   <= i_base;
         r_remain <= i_count;
      end else if (i_step) begin
         r_addr   <= r_addr + ADDR'(1);
         r_remain <= r_remain - ADDR'(1);
      end
   end

   assign o_addr = r_addr;
   // Remaining count reaches zero on the next step.
   assign o_last = (r_remain == ADDR'(1));

endmodule

// File: rtl/rsa_decrypt_sequencer.sv
// Walks a block of ciphertext words through the Mod_Exp core one word at a time.
// Latency: FETCH+LAUNCH+WAIT(>=2)+EMIT per word; out_valid holds until out_ready.
module rsa_decrypt_sequencer
   import rsa_pkg::*;
#(
   parameter int ARQ     = RSA_ARQ,
   parameter int ADDR    = RSA_ADDR,
   parameter int KEY_N   = RSA_KEY_N,
   parameter int KEY_D   = RSA_KEY_D,
   parameter int TIMEOUT = RSA_TIMEOUT
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [ADDR-1:0]  i_base_addr,
   input  logic [ADDR-1:0]  i_count,
   output logic [ADDR-1:0]  o_mem_addr,
   input  logic [ARQ-1:0]   i_mem_data,
   output logic [2*ARQ-1:0] o_mx_operand,
   output logic [2*ARQ-1:0] o_mx_mod,
   output logic [2*ARQ-1:0] o_mx_exp,
   output logic             o_mx_rst,
   input  logic             i_mx_finish,
   input  logic [ARQ-1:0]   i_mx_result,
   output logic [ARQ-1:0]   o_out_data,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_error
);

   localparam int WCW = $clog2(TIMEOUT + 1);

   rsa_seq_state_t   r_state;
   logic [WCW-1:0]   r_wait_cnt;
   logic [2*ARQ-1:0] r_operand;
   logic [ARQ-1:0]   r_out_data;
   logic             r_out_valid;
   logic             r_mx_rst;
   logic             r_busy;
   logic             r_done;
   logic             r_error;

   logic            w_load;
   logic            w_step;
   logic            w_last;
   logic [ADDR-1:0] w_addr;

   assign w_load = (r_state == S_IDLE) && i_start;
   assign w_step = (r_state == S_EMIT) && r_out_valid && i_out_ready;

   rsa_addr_counter #(
      .ADDR (ADDR)
   ) u_addr_counter (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_load),
      .i_base  (i_base_addr),
      .i_count (i_count),
      .i_step  (w_step),
      .o_addr  (w_addr),
      .o_last  (w_last)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_wait_cnt  <= '0;
         r_operand   <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_mx_rst    <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_mx_rst <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_error <= 1'b0;
                  r_busy  <= 1'b1;
                  if (i_count == '0) begin
                     r_done  <= 1'b1;
                     r_state <= S_FINISH;
                  end else begin
                     r_state <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               r_operand <= {{ARQ{1'b0}}, i_mem_data};
               r_mx_rst  <= 1'b1;
               r_state   <= S_LAUNCH;
            end
            S_LAUNCH: begin
               r_wait_cnt <= '0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               r_wait_cnt <= r_wait_cnt + WCW'(1);
               // A finish seen in the first WAIT cycle may be left over from the previous word.
               if ((r_wait_cnt != '0) && i_mx_finish) begin
                  r_out_data  <= i_mx_result;
                  r_out_valid <= 1'b1;
                  r_state     <= S_EMIT;
               end else if (r_wait_cnt == WCW'(TIMEOUT - 1)) begin
                  r_error <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_FINISH;
               end
            end
            S_EMIT: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  if (w_last) begin
                     r_done  <= 1'b1;
                     r_state <= S_FINISH;
                  end else begin
                     r_state <= S_FETCH;
                  end
               end
            end
            S_FINISH: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_mem_addr   = w_addr;
   assign o_mx_operand = r_operand;
   assign o_mx_mod     = (2*ARQ)'(KEY_N);
   assign o_mx_exp     = (2*ARQ)'(KEY_D);
   assign o_mx_rst     = r_mx_rst;
   assign o_out_data   = r_out_data;
   assign o_out_valid  = r_out_valid;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_error      = r_error;

endmodule

// File: doc/rsa_decrypt_sequencer.md
# rsa_decrypt_sequencer

Sequencer that drives the modular-exponentiation datapath over a block of ciphertext words held in the encrypted-word memory. On `start` it walks `count` consecutive addresses from `base_addr`, zero-extends each word to the exponentiator operand width, restarts the exponentiator, waits for `finish`, and hands each plaintext word out on a valid/ready stream. It sits between the ciphertext memory, the `Mod_Exp` core and whatever consumes plaintext, and replaces the free-running hookup with controlled, one-word-at-a-time operation.

## Interface
- `ARQ`, 16, plaintext/ciphertext word width.
- `ADDR`, 18, memory address width.
- `KEY_N`, 1927, modulus driven to the exponentiator.
- `KEY_D`, 1349, private exponent driven to the exponentiator.
- `TIMEOUT`, 65535, maximum cycles to wait for `mx_finish` per word.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR  first address; captured on accepted `start`.
- `count`  in  ADDR  number of words; captured on accepted `start`.
- `mem_addr`  out  ADDR  address to ciphertext memory (combinational read).
- `mem_data`  in  ARQ  word at `mem_addr`.
- `mx_operand`  out  2*ARQ  registered, zero-extended ciphertext.
- `mx_mod`  out  2*ARQ  constant `KEY_N`, zero-extended.
- `mx_exp`  out  2*ARQ  constant `KEY_D`, zero-extended.
- `mx_rst`  out  1  restart pulse to exponentiator.
- `mx_finish`  in  1  exponentiator completion level.
- `mx_result`  in  ARQ  exponentiator result.
- `out_data`  out  ARQ  plaintext word.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when the block finishes.
- `error`  out  1  sticky timeout flag; cleared on next accepted `start` or `rst`.

## Operation
- States: IDLE, FETCH, LAUNCH, WAIT, EMIT, FINISH.
- IDLE: `start`=1 captures `base_addr` into `addr_q` and `count` into `remain_q`, clears `error`. If `count`=0, go to FINISH; otherwise go to FETCH.
- FETCH: `mem_addr`=`addr_q`. Register `{ARQ'0, mem_data}` into `mx_operand`. Go to LAUNCH.
- LAUNCH: `mx_rst`=1 for exactly this cycle. Clear the wait counter. Go to WAIT.
- WAIT: `mx_finish` is ignored in the first WAIT cycle, which blanks any stale finish. From the second cycle on, `mx_finish`=1 latches `mx_result` into `out_data` and goes to EMIT. If the wait counter reaches `TIMEOUT` first: set `error` and go to FINISH, abandoning the remaining words.
- EMIT: `out_valid`=1 and `out_data` is held stable until `out_valid && out_ready`. On that handshake:
  - `addr_q` += 1, wrapping modulo 2^ADDR (0x3FFFF goes to 0);
  - `remain_q` −= 1;
  - if the new `remain_q` is 0, go to FINISH; else go to FETCH.
- FINISH: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored, with no queuing.
- `mem_addr` equals `addr_q` in every state.
- `mx_mod` and `mx_exp` are constant and never change.

## Timing
- Reset: state=IDLE; `addr_q`, `remain_q`, `mx_operand`, `out_data` and the wait counter are 0. `mx_rst`, `out_valid`, `busy`, `done` and `error` are 0. `mem_addr` is 0.
- `rst` mid-operation: the same values as above apply on the next edge. An in-flight word is dropped and `done` does not fire.
- `start` accepted at edge T: `busy` is high from T+1. `mx_rst` is high in the cycle after T+1, i.e. LAUNCH at T+2.
- Per-word latency from FETCH entry to `out_valid`: 3 cycles + exponentiator compute time, when `mx_finish` asserts at the earliest (second WAIT cycle).
- When `out_ready` is held high, the EMIT→FETCH turnaround is 1 cycle. Back-to-back words are therefore separated by FETCH + LAUNCH + WAIT(≥2) + EMIT.
- `done` asserts the cycle after the last handshake (or after the timeout, or after IDLE when `count`=0). `busy` falls the cycle after `done`.
- `out_valid` never drops without a handshake, except on `rst` or timeout (timeout is only reachable from WAIT, never from EMIT).

## Structure
- Shared package `rsa_pkg` holds:
  - state enum `rsa_seq_state_t`;
  - the default `KEY_N` and `KEY_D` localparams;
  - the `ARQ` and `ADDR` defaults used across the processor.
- Natural sub-module `rsa_addr_counter` holds `addr_q` and `remain_q`: load, step with wrap, and a zero flag. The FSM, wait counter and output registers stay in the top.
- Zero extension is inline; no separate extender instance.

## Test plan
- Memory words 0x0001 and 0x0002 at addresses 0 and 1, `count`=2, `out_ready`=1, behavioural exponentiator with 5-cycle latency (x^1349 mod 1927) → two `out_valid` beats, each equal to the model result, in address order. `done` pulses once, and `mx_rst` pulses exactly twice.
- `base_addr`=0x3FFFF, `count`=2 → `mem_addr` sequence 0x3FFFF then 0x00000.
- `count`=0 → `busy` high for 1 cycle, `done` pulse, no `mx_rst`, no `out_valid`.
- `out_ready` held low for 10 cycles in EMIT → `out_valid` and `out_data` stable throughout. The next FETCH occurs only after `out_ready` rises.
- Exponentiator that never asserts finish, with `TIMEOUT`=16 → `error`=1 on the 16th counted WAIT cycle, `done` pulse, return to IDLE. A new `start` clears `error`.
- Stale `mx_finish`=1 held across LAUNCH → not accepted in the first WAIT cycle. Separately, `rst` in WAIT → all outputs zero next cycle and no `done`.
